tx_fifo_write_arbiter: RTL

Shares the single Tx FIFO write port between two requesters: CPU words arriving from the AXI-lite register path, and an autonomous periodic beacon carrying the exhibit ID word. Sequences each FIFO write as a one-cycle write strobe followed by a wait for the FIFO's write-success acknowledge, with timeout recovery. Sits between the AXI-lite slave wrapper and the Tx FIFO, in the s_axi_aclk domain.

---
 rtl/tx_pkg.sv | 21 ++
 rtl/tx_fifo_write_arbiter_if.sv | 39 +++
 rtl/beacon_timer.sv | 51 +++++
 rtl/tx_fifo_write_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the Tx FIFO write arbiter slice.
// Contents:
//   DATA_W_DEF   - default FIFO/requester word width
//   state_t      - arbiter FSM states (IDLE, WRITE, WAIT_ACK)
//   grant_t      - grant source (GRANT_CPU, GRANT_BEACON)
package tx_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CPU    = 1'b0,
        GRANT_BEACON = 1'b1
    } grant_t;

endpackage

// File: rtl/tx_fifo_write_arbiter_if.sv
// Bus bundle between the requesters/Tx FIFO and the write arbiter.
// Ports (as signals):
//   cpu_valid/cpu_data/cpu_ready      - CPU word handshake
//   beacon_en/beacon_word             - beacon enable and exhibit ID word
//   fifo_full/fifo_wr_success         - Tx FIFO status
//   fifo_wr_en/fifo_din               - Tx FIFO write port
//   busy/beacon_pending/timeout_irq/drop_count - status
// Modports: slave = arbiter side, master = requester/FIFO environment side.
interface tx_fifo_write_arbiter_if
    import tx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = 8
);
    logic              cpu_valid;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ready;
    logic              beacon_en;
    logic [DATA_W-1:0] beacon_word;
    logic              fifo_full;
    logic              fifo_wr_success;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_din;
    logic              busy;
    logic              beacon_pending;
    logic              timeout_irq;
    logic [CNT_W-1:0]  drop_count;

    modport slave (
        input  cpu_valid, cpu_data, beacon_en, beacon_word, fifo_full, fifo_wr_success,
        output cpu_ready, fifo_wr_en, fifo_din, busy, beacon_pending, timeout_irq, drop_count
    );

    modport master (
        output cpu_valid, cpu_data, beacon_en, beacon_word, fifo_full, fifo_wr_success,
        input  cpu_ready, fifo_wr_en, fifo_din, busy, beacon_pending, timeout_irq, drop_count
    );

endinterface

// File: rtl/beacon_timer.sv
// Periodic beacon timer: counts 0..BEACON_PERIOD-1 while enabled and raises a
// pending flag on every wrap. A wrap that finds the flag still set (and not
// being granted on the same edge) produces a one-cycle miss pulse.
// Ports:
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_en           - timer enable; low holds counter at 0 and clears pending
//   i_grant        - arbiter granted the beacon this cycle
//   o_pending      - beacon due, not yet granted
//   o_miss         - combinational pulse, beacon lost because one was pending
module beacon_timer #(
    parameter int unsigned BEACON_PERIOD = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_grant,
    output logic o_pending,
    output logic o_miss
);

    localparam int unsigned TW = $clog2(BEACON_PERIOD);
    localparam logic [TW-1:0] LAST = TW'(BEACON_PERIOD - 1);

    logic [TW-1:0] r_cnt;
    logic          r_pending;
    logic          w_wrap;

    assign w_wrap    = i_en && (r_cnt == LAST);
    // A grant on the wrap edge consumes the old beacon, so it is not a miss.
    assign o_miss    = w_wrap && r_pending && !i_grant;
    assign o_pending = r_pending;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else if (!i_en) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            // Wrap has priority over grant: the new beacon stays pending.
            if (w_wrap) begin
                r_pending <= 1'b1;
            end else if (i_grant) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tx_fifo_write_arbiter.sv
// Shares the Tx FIFO write port between CPU words and the periodic beacon.
// Each write is a one-cycle strobe (WRITE) followed by a wait for the FIFO's
// write-success acknowledge (WAIT_ACK) with timeout recovery.
// Ports:
//   s_axi_aclk    - clock
//   s_axi_aresetn - synchronous active-low reset
//   bus           - slave side of tx_fifo_write_arbiter_if (requesters, FIFO, status)
module tx_fifo_write_arbiter
    import tx_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned BEACON_PERIOD = 1000000,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    tx_fifo_write_arbiter_if.slave  bus
);

    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    grant_t            r_last_grant;
    grant_t            w_sel;
    logic              w_grant;
    logic              w_timeout;
    logic              w_wr_en;
    logic              w_cpu_ready;
    logic              w_busy;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_fifo_din;
    logic              r_timeout_irq;
    logic [CNT_W-1:0]  r_drop_count;
    logic [CNT_W:0]    w_drop_sum;
    logic              w_beacon_pending;
    logic              w_beacon_miss;
    logic              w_beacon_grant;

    assign w_beacon_grant = w_grant && (w_sel == GRANT_BEACON);

    beacon_timer #(
        .BEACON_PERIOD (BEACON_PERIOD)
    ) u_beacon_timer (
        .i_clk     (s_axi_aclk),
        .i_rst_n   (s_axi_aresetn),
        .i_en      (bus.beacon_en),
        .i_grant   (w_beacon_grant),
        .o_pending (w_beacon_pending),
        .o_miss    (w_beacon_miss)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel       = GRANT_CPU;
        w_timeout   = 1'b0;
        w_wr_en     = 1'b0;
        w_cpu_ready = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (!bus.fifo_full && (bus.cpu_valid || w_beacon_pending)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = WRITE;
                    if (bus.cpu_valid && w_beacon_pending) begin
                        w_sel = (r_last_grant == GRANT_CPU) ? GRANT_BEACON : GRANT_CPU;
                    end else if (bus.cpu_valid) begin
                        w_sel = GRANT_CPU;
                    end else begin
                        w_sel = GRANT_BEACON;
                    end
                end
            end
            WRITE: begin
                w_wr_en = 1'b1;
                // r_last_grant always names the source of the word in flight.
                w_cpu_ready = (r_last_grant == GRANT_CPU);
                w_state_nxt = bus.fifo_wr_success ? IDLE : WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.fifo_wr_success) begin
                    w_state_nxt = IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Timeout and missed beacon can coincide; both count, saturating.
    assign w_drop_sum = {1'b0, r_drop_count}
                      + {{CNT_W{1'b0}}, w_timeout}
                      + {{CNT_W{1'b0}}, w_beacon_miss};

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state       <= IDLE;
            r_last_grant  <= GRANT_BEACON;
            r_to_cnt      <= '0;
            r_fifo_din    <= '0;
            r_timeout_irq <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_timeout_irq <= w_timeout;
            r_to_cnt      <= (r_state == WAIT_ACK) ? r_to_cnt + 1'b1 : '0;
            r_drop_count  <= w_drop_sum[CNT_W] ? CNT_MAX : w_drop_sum[CNT_W-1:0];
            if (w_grant) begin
                r_last_grant <= w_sel;
                r_fifo_din   <= (w_sel == GRANT_CPU) ? bus.cpu_data : bus.beacon_word;
            end
        end
    end

    assign bus.fifo_wr_en     = w_wr_en;
    assign bus.cpu_ready      = w_cpu_ready;
    assign bus.busy           = w_busy;
    assign bus.fifo_din       = r_fifo_din;
    assign bus.beacon_pending = w_beacon_pending;
    assign bus.timeout_irq    = r_timeout_irq;
    assign bus.drop_count     = r_drop_count;

endmodule
